// File: rtl/id_ex_alu_decode_if.sv
// rtl/id_ex_alu_decode_if.sv - ID-to-EX ALU control bundle between the ID stage and the ID/EX register
interface id_ex_alu_decode_if;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic        ex_hold;
    logic        ex_flush;
    logic        ex_valid;
    logic [5:0]  ex_alu_fun;
    logic        ex_sign;
    logic [31:0] ex_op_a;
    logic [31:0] ex_op_b;
    logic [31:0] ex_rt_data;
    logic [4:0]  ex_wr_reg;
    logic        ex_reg_wr;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic        ex_branch;
    logic        ex_undef;

    modport master (
        output id_valid, id_instr, id_rs_data, id_rt_data, ex_hold, ex_flush,
        input  ex_valid, ex_alu_fun, ex_sign, ex_op_a, ex_op_b, ex_rt_data,
               ex_wr_reg, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_branch, ex_undef
    );

    modport slave (
        input  id_valid, id_instr, id_rs_data, id_rt_data, ex_hold, ex_flush,
        output ex_valid, ex_alu_fun, ex_sign, ex_op_a, ex_op_b, ex_rt_data,
               ex_wr_reg, ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_branch, ex_undef
    );
endinterface

// File: rtl/id_ex_alu_decode.sv
// rtl/id_ex_alu_decode.sv - ID-stage ALU control decode and ID/EX pipeline register
module id_ex_alu_decode #(
    parameter bit RESET_NOP = 1'b1,
    parameter int IMM_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    id_ex_alu_decode_if.slave bus
);
    localparam logic [5:0] ALU_ADD   = 6'b000000;
    localparam logic [5:0] ALU_SUB   = 6'b000001;
    localparam logic [5:0] ALU_AND   = 6'b011000;
    localparam logic [5:0] ALU_OR    = 6'b011110;
    localparam logic [5:0] ALU_XOR   = 6'b010110;
    localparam logic [5:0] ALU_NOR   = 6'b010001;
    localparam logic [5:0] ALU_LT    = 6'b110101;
    localparam logic [5:0] ALU_SLL   = 6'b100000;
    localparam logic [5:0] ALU_SRL   = 6'b100001;
    localparam logic [5:0] ALU_SRA   = 6'b100011;
    localparam logic [5:0] ALU_PASSA = 6'b011010;
    localparam logic [5:0] ALU_EQ    = 6'b110011;
    localparam logic [5:0] ALU_NE    = 6'b110001;
    localparam logic [5:0] ALU_LEZ   = 6'b111101;
    localparam logic [5:0] ALU_GTZ   = 6'b111111;
    localparam logic [5:0] ALU_LTZ   = 6'b111011;

    typedef struct packed {
        logic valid;
        logic reg_wr;
        logic mem_rd;
        logic mem_wr;
        logic branch;
        logic undef;
    } ctrl_t;

    typedef struct packed {
        logic [5:0]  alu_fun;
        logic        sign;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] rt_data;
        logic [4:0]  wr_reg;
    } data_t;

    logic [5:0]       op;
    logic [5:0]       funct;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [4:0]       shamt;
    logic [IMM_W-1:0] imm;
    logic [31:0]      imm_sext;
    logic [31:0]      imm_zext;
    logic             unused_rs_field;

    assign op       = bus.id_instr[31:26];
    assign rt       = bus.id_instr[20:16];
    assign rd       = bus.id_instr[15:11];
    assign shamt    = bus.id_instr[10:6];
    assign funct    = bus.id_instr[5:0];
    assign imm      = bus.id_instr[IMM_W-1:0];
    assign imm_sext = {{(32-IMM_W){imm[IMM_W-1]}}, imm};
    assign imm_zext = {{(32-IMM_W){1'b0}}, imm};
    // rs arrives already read out of the register file as id_rs_data
    assign unused_rs_field = ^bus.id_instr[25:21];

    ctrl_t dc;
    data_t dd;

    always_comb begin
        dc         = '0;
        dd         = '0;
        dd.op_a    = bus.id_rs_data;
        dd.op_b    = bus.id_rt_data;
        dd.rt_data = bus.id_rt_data;
        case (op)
            6'h00: begin
                dd.wr_reg = rd;
                dc.reg_wr = 1'b1;
                case (funct)
                    6'h20: begin dd.alu_fun = ALU_ADD; dd.sign = 1'b1; end
                    6'h21: dd.alu_fun = ALU_ADD;
                    6'h22: begin dd.alu_fun = ALU_SUB; dd.sign = 1'b1; end
                    6'h23: dd.alu_fun = ALU_SUB;
                    6'h24: dd.alu_fun = ALU_AND;
                    6'h25: dd.alu_fun = ALU_OR;
                    6'h26: dd.alu_fun = ALU_XOR;
                    6'h27: dd.alu_fun = ALU_NOR;
                    6'h2A: begin dd.alu_fun = ALU_LT; dd.sign = 1'b1; end
                    6'h2B: dd.alu_fun = ALU_LT;
                    // The ALU shifts B by A[4:0], so shamt rides on operand A
                    6'h00: begin dd.alu_fun = ALU_SLL; dd.op_a = {27'b0, shamt}; end
                    6'h02: begin dd.alu_fun = ALU_SRL; dd.op_a = {27'b0, shamt}; end
                    6'h03: begin dd.alu_fun = ALU_SRA; dd.op_a = {27'b0, shamt}; end
                    6'h08: begin dd.alu_fun = ALU_PASSA; dc.reg_wr = 1'b0; end
                    6'h09: dd.alu_fun = ALU_PASSA;
                    default: dc.undef = 1'b1;
                endcase
            end
            6'h08: begin dd.op_b = imm_sext; dd.sign = 1'b1; dd.wr_reg = rt; dc.reg_wr = 1'b1; end
            6'h09: begin dd.op_b = imm_sext; dd.wr_reg = rt; dc.reg_wr = 1'b1; end
            6'h0A: begin
                dd.alu_fun = ALU_LT; dd.op_b = imm_sext; dd.sign = 1'b1;
                dd.wr_reg = rt; dc.reg_wr = 1'b1;
            end
            6'h0B: begin dd.alu_fun = ALU_LT; dd.op_b = imm_sext; dd.wr_reg = rt; dc.reg_wr = 1'b1; end
            6'h0C: begin dd.alu_fun = ALU_AND; dd.op_b = imm_zext; dd.wr_reg = rt; dc.reg_wr = 1'b1; end
            6'h0F: begin dd.op_a = '0; dd.op_b = imm_zext << 16; dd.wr_reg = rt; dc.reg_wr = 1'b1; end
            6'h23: begin dd.op_b = imm_sext; dd.wr_reg = rt; dc.reg_wr = 1'b1; dc.mem_rd = 1'b1; end
            6'h2B: begin dd.op_b = imm_sext; dd.wr_reg = rt; dc.mem_wr = 1'b1; end
            6'h04: begin dd.alu_fun = ALU_EQ;  dd.sign = 1'b1; dd.wr_reg = rt; dc.branch = 1'b1; end
            6'h05: begin dd.alu_fun = ALU_NE;  dd.sign = 1'b1; dd.wr_reg = rt; dc.branch = 1'b1; end
            6'h06: begin dd.alu_fun = ALU_LEZ; dd.sign = 1'b1; dd.wr_reg = rt; dc.branch = 1'b1; end
            6'h07: begin dd.alu_fun = ALU_GTZ; dd.sign = 1'b1; dd.wr_reg = rt; dc.branch = 1'b1; end
            6'h01: begin
                if (rt == 5'd0) begin
                    dd.alu_fun = ALU_LTZ; dd.sign = 1'b1; dc.branch = 1'b1;
                end else begin
                    dc.undef = 1'b1;
                end
            end
            6'h02: ;
            6'h03: begin dd.wr_reg = 5'd31; dc.reg_wr = 1'b1; end
            default: dc.undef = 1'b1;
        endcase
        if (dc.undef) begin
            dd.alu_fun = '0;
            dd.sign    = 1'b0;
            dd.wr_reg  = '0;
            dc.reg_wr  = 1'b0;
            dc.mem_rd  = 1'b0;
            dc.mem_wr  = 1'b0;
            dc.branch  = 1'b0;
        end
        if (dd.wr_reg == 5'd0) dc.reg_wr = 1'b0;
        dc.valid = 1'b1;
    end

    // Flush and empty ID slots both load the all-zero bubble
    logic  take;
    logic  en;
    ctrl_t nc;
    data_t nd;
    ctrl_t cr;
    data_t dr;

    assign take = bus.id_valid && !bus.ex_flush;
    assign en   = bus.ex_flush || !bus.ex_hold;
    assign nc   = take ? dc : '0;
    assign nd   = take ? dd : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cr <= '0;
        end else if (en) begin
            cr <= nc;
        end
    end

    generate
        if (RESET_NOP) begin : g_data_rst
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    dr <= '0;
                end else if (en) begin
                    dr <= nd;
                end
            end
        end else begin : g_data_norst
            always_ff @(posedge clk) begin
                if (en) begin
                    dr <= nd;
                end
            end
        end
    endgenerate

    assign bus.ex_valid   = cr.valid;
    assign bus.ex_reg_wr  = cr.reg_wr;
    assign bus.ex_mem_rd  = cr.mem_rd;
    assign bus.ex_mem_wr  = cr.mem_wr;
    assign bus.ex_branch  = cr.branch;
    assign bus.ex_undef   = cr.undef;
    assign bus.ex_alu_fun = dr.alu_fun;
    assign bus.ex_sign    = dr.sign;
    assign bus.ex_op_a    = dr.op_a;
    assign bus.ex_op_b    = dr.op_b;
    assign bus.ex_rt_data = dr.rt_data;
    assign bus.ex_wr_reg  = dr.wr_reg;
endmodule
